// File: rtl/alu_operand_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_operand_seq_pkg
// Shared types and constants for the ALU operand-fetch / write-back sequencer.
//   seq_state_t  : sequencer FSM states (IDLE -> EXEC -> WB -> IDLE)
//   ALU_SEL_W    : width of the ALU function select
//   DEF_*        : default datapath, immediate and register-file sizes
// -----------------------------------------------------------------------------
package alu_operand_seq_pkg;

  localparam int ALU_SEL_W  = 3;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_IMM_W  = 16;
  localparam int DEF_NREG   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_operand_seq_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// NREG x DATA_W register file: one synchronous write port, three asynchronous
// read ports (operand A, operand B, debug) and an asynchronous active-low
// clear of every entry.
// Ports:
//   clk, rst_n          clock / async active-low clear
//   we, waddr, wdata    write port
//   ra_addr / ra_data   operand A read
//   rb_addr / rb_data   operand B read
//   dbg_addr / dbg_data debug read
// -----------------------------------------------------------------------------
module alu_regfile
  import alu_operand_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see committed contents only, so operands captured on the accept
  // edge are the pre-edge values even when the same edge performs a write.
  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_operand_seq.sv
// -----------------------------------------------------------------------------
// alu_operand_seq
// Operand-fetch and write-back sequencer in front of a combinational ALU.
// Accepts reg-reg / reg-imm commands on a valid/ready handshake, drives the
// ALU operands and select from registers, then writes the ALU result back.
// One command every three cycles: accept (IDLE) -> EXEC -> WB.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_op/rd/ra/rb/imm_en/imm       command fields
//   alu_a, alu_b, alu_s              registered ALU inputs
//   alu_result                       combinational ALU output
//   done, done_data                  one-cycle write-back pulse and value
//   ld_en, ld_addr, ld_data          external register load (IDLE only)
//   dbg_addr, dbg_data               asynchronous debug read
// -----------------------------------------------------------------------------
module alu_operand_seq
  import alu_operand_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int AW     = $clog2(NREG),
  parameter int IMM_W  = DEF_IMM_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ALU_SEL_W-1:0] cmd_op,
  input  logic [AW-1:0]        cmd_rd,
  input  logic [AW-1:0]        cmd_ra,
  input  logic [AW-1:0]        cmd_rb,
  input  logic                 cmd_imm_en,
  input  logic [IMM_W-1:0]     cmd_imm,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [ALU_SEL_W-1:0] alu_s,
  input  logic [DATA_W-1:0]    alu_result,
  output logic                 done,
  output logic [DATA_W-1:0]    done_data,
  input  logic                 ld_en,
  input  logic [AW-1:0]        ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic [AW-1:0]        dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);

  seq_state_t           state_q, state_d;
  logic [DATA_W-1:0]    alu_a_q, alu_a_d;
  logic [DATA_W-1:0]    alu_b_q, alu_b_d;
  logic [ALU_SEL_W-1:0] alu_s_q, alu_s_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic                 done_q, done_d;
  logic [DATA_W-1:0]    done_data_q, done_data_d;
  logic                 cmd_ready_q, cmd_ready_d;

  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [DATA_W-1:0]    rf_wdata;
  logic [DATA_W-1:0]    ra_data;
  logic [DATA_W-1:0]    rb_data;
  logic [DATA_W-1:0]    imm_sext;

  assign imm_sext = {{(DATA_W-IMM_W){cmd_imm[IMM_W-1]}}, cmd_imm};

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (cmd_ra),
    .ra_data  (ra_data),
    .rb_addr  (cmd_rb),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Next-state logic. The write port is shared: the ALU write-back owns it
  // in EXEC; in IDLE an external load may use it only when no command is
  // accepted on the same edge (the command wins).
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    rd_d        = rd_q;
    done_d      = done_q;
    done_data_d = done_data_q;
    rf_we       = 1'b0;
    rf_waddr    = ld_addr;
    rf_wdata    = ld_data;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          alu_a_d = ra_data;
          alu_b_d = cmd_imm_en ? imm_sext : rb_data;
          alu_s_d = cmd_op;
          rd_d    = cmd_rd;
          state_d = EXEC;
        end else if (ld_en) begin
          rf_we = 1'b1;
        end
      end
      EXEC: begin
        rf_we       = 1'b1;
        rf_waddr    = rd_q;
        rf_wdata    = alu_result;
        done_d      = 1'b1;
        done_data_d = alu_result;
        state_d     = WB;
      end
      WB: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready is a registered decode of the next state, so it never depends
    // combinationally on cmd_valid.
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      rd_q        <= '0;
      done_q      <= 1'b0;
      done_data_q <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      rd_q        <= rd_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign done      = done_q;
  assign done_data = done_data_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_seq
// Self-checking bench for alu_operand_seq. The bench supplies the ALU
// (aluModel) and keeps a shadow register file; each accepted command pushes
// its expected write-back value, which a monitor pops whenever done is high.
// -----------------------------------------------------------------------------
module tb_alu_operand_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_ra;
  logic [2:0]  cmd_rb;
  logic        cmd_imm_en;
  logic [15:0] cmd_imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_s;
  logic [31:0] alu_result;
  logic        done;
  logic [31:0] done_data;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int          checks = 0;
  int          failures = 0;
  int          cycleCnt = 0;
  logic [31:0] shadowRegs [8];
  logic [31:0] expQ [$];
  logic [31:0] monExp;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure the spacing between accepts.
  always @(posedge clk) cycleCnt++;

  // Reference ALU: eight distinct functions selected by s.
  function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return ~a;
    endcase
  endfunction

  // The bench plays the role of the combinational ALU next to the sequencer.
  assign alu_result = aluModel(alu_a, alu_b, alu_s);

  alu_operand_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_ra     (cmd_ra),
    .cmd_rb     (cmd_rb),
    .cmd_imm_en (cmd_imm_en),
    .cmd_imm    (cmd_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_result (alu_result),
    .done       (done),
    .done_data  (done_data),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every cycle with done high must consume exactly one
  // expected result; a done with nothing outstanding is itself an error.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("done_unexpected", 32'd1, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("done_data", done_data, monExp);
      end
    end
  end

  // Load one register through ld_en and confirm it through the debug port.
  task automatic ldReg(input logic [2:0] addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
    shadowRegs[addr] = data;
    dbg_addr = addr;
    #1;
    checkOutput("ld_readback", dbg_data, data);
  endtask

  // Sweep all debug addresses against the shadow register file.
  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dbg_addr = 3'(i);
      #1;
      checkOutput(tag, dbg_data, shadowRegs[i]);
    end
    @(posedge clk); #1;
  endtask

  // Drive one command and follow it through EXEC and WB.
  // ldMode: 0 = no load, 1 = load asserted together with the command,
  //         2 = load asserted during EXEC and WB (ld_addr/ld_data preset).
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                               input logic [2:0] rb, input logic immEn, input logic [15:0] imm,
                               input int ldMode);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          waitCycles;
    a = shadowRegs[ra];
    b = immEn ? {{16{imm[15]}}, imm} : shadowRegs[rb];
    r = aluModel(a, b, op);
    cmd_op     = op;
    cmd_rd     = rd;
    cmd_ra     = ra;
    cmd_rb     = rb;
    cmd_imm_en = immEn;
    cmd_imm    = imm;
    cmd_valid  = 1'b1;
    if (ldMode == 1) ld_en = 1'b1;
    waitCycles = 0;
    while (cmd_ready !== 1'b1 && waitCycles < 10) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (cmd_ready !== 1'b1) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      ld_en = 1'b0;
      return;
    end
    expQ.push_back(r);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ld_en = 1'b0;
    if (ldMode == 2) ld_en = 1'b1;
    checkOutput("exec_alu_a", alu_a, a);
    checkOutput("exec_alu_b", alu_b, b);
    checkOutput("exec_alu_s", {29'd0, alu_s}, {29'd0, op});
    checkOutput("exec_ready_low", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("wb_done_high", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    ld_en = 1'b0;
    shadowRegs[rd] = r;
    dbg_addr = rd;
    #1;
    checkOutput("wb_regfile", dbg_data, r);
    checkOutput("idle_done_low", {31'd0, done}, 32'd0);
    checkOutput("idle_ready_high", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Hard time limit so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    logic [31:0] r1;
    logic [31:0] r2;
    int          t1;
    int          t2;
    int          lowCycles;
    int          waitCycles;

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_rd     = '0;
    cmd_ra     = '0;
    cmd_rb     = '0;
    cmd_imm_en = 1'b0;
    cmd_imm    = '0;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    dbg_addr   = '0;
    for (int i = 0; i < 8; i++) shadowRegs[i] = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_done_data", done_data, 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_alu_s", {29'd0, alu_s}, 32'd0);
    checkAllRegs("rst_regs");

    // Register-register command across all eight ALU functions.
    ldReg(3'd1, 32'd1);
    ldReg(3'd2, 32'd3);
    for (int op = 0; op < 8; op++) begin
      applyStimulus(3'(op), 3'd4, 3'd1, 3'd2, 1'b0, 16'h0000, 0);
    end

    // Immediate operand: negative and positive sign extension.
    ldReg(3'd1, 32'd5);
    applyStimulus(3'd1, 3'd3, 3'd1, 3'd2, 1'b1, 16'hFFFF, 0);
    applyStimulus(3'd0, 3'd5, 3'd1, 3'd2, 1'b1, 16'h7FFF, 0);

    // Back-to-back: valid held high; second command reads the first's rd.
    checkOutput("b2b_ready_pre", {31'd0, cmd_ready}, 32'd1);
    r1 = aluModel(shadowRegs[1], shadowRegs[2], 3'd0);
    cmd_op = 3'd0; cmd_rd = 3'd5; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_imm_en = 1'b0;
    cmd_valid = 1'b1;
    expQ.push_back(r1);
    @(posedge clk); #1;
    t1 = cycleCnt;
    shadowRegs[5] = r1;
    r2 = aluModel(shadowRegs[5], shadowRegs[2], 3'd0);
    cmd_rd = 3'd6; cmd_ra = 3'd5;
    expQ.push_back(r2);
    lowCycles = 0;
    waitCycles = 0;
    while (cmd_ready !== 1'b1 && waitCycles < 10) begin
      lowCycles++;
      @(posedge clk); #1;
      waitCycles++;
    end
    @(posedge clk); #1;
    t2 = cycleCnt;
    cmd_valid = 1'b0;
    checkOutput("b2b_ready_low_cycles", 32'(lowCycles), 32'd2);
    checkOutput("b2b_accept_spacing", 32'(t2 - t1), 32'd3);
    checkOutput("b2b_second_alu_a", alu_a, r1);
    repeat (2) @(posedge clk);
    #1;
    shadowRegs[6] = r2;
    dbg_addr = 3'd6;
    #1;
    checkOutput("b2b_second_wb", dbg_data, r2);

    // Self-reference: rd == ra.
    ldReg(3'd1, 32'd1);
    applyStimulus(3'd0, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0000, 0);

    // Load colliding with an accepted command is dropped.
    ld_addr = 3'd7;
    ld_data = 32'hDEADBEEF;
    applyStimulus(3'd2, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0000, 1);
    dbg_addr = 3'd7;
    #1;
    checkOutput("collide_ld_dropped", dbg_data, shadowRegs[7]);

    // Load during EXEC/WB is ignored.
    ld_addr = 3'd3;
    ld_data = 32'h12345678;
    applyStimulus(3'd3, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0000, 2);
    dbg_addr = 3'd3;
    #1;
    checkOutput("exec_ld_ignored", dbg_data, shadowRegs[3]);

    // Reset in the middle of EXEC: no done, everything cleared.
    @(posedge clk); #1;
    cmd_op = 3'd0; cmd_rd = 3'd3; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_imm_en = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    checkOutput("midrst_alu_a", alu_a, 32'd0);
    checkOutput("midrst_alu_b", alu_b, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) shadowRegs[i] = '0;
    #1;
    checkOutput("midrst_ready_after", {31'd0, cmd_ready}, 32'd1);
    checkAllRegs("midrst_regs");
    repeat (2) @(posedge clk);
    #1;

    // Normal operation after the aborted command.
    ldReg(3'd1, 32'd7);
    applyStimulus(3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
